// File: rtl/opll_write_sequencer.sv
// rtl/opll_write_sequencer.sv - OPLL register-write sequencer
// Turns (addr, data) requests into timed address/data bus cycles with WR strobes.
module opll_write_sequencer #(
   parameter int unsigned WR_PULSE       = 4,
   parameter int unsigned ADDR_WAIT      = 12,
   parameter int unsigned DATA_WAIT      = 84,
   parameter int unsigned SKIP_SAME_ADDR = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_addr,
   input  logic [7:0] in_data,
   output logic [7:0] o_D,
   output logic       o_A0,
   output logic       o_WR,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_WR, S_ADDR_WAIT, S_DATA_WR, S_DATA_WAIT
   } state_t;

   localparam logic [7:0] C_WR_LOAD   = 8'(WR_PULSE - 1);
   localparam logic [7:0] C_AW_LOAD   = 8'(ADDR_WAIT - 1);
   localparam logic [7:0] C_DW_LOAD   = 8'(DATA_WAIT - 1);
   localparam logic       C_SKIP_EN   = (SKIP_SAME_ADDR != 0);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_addr, w_addr_nxt;
   logic [7:0] r_data, w_data_nxt;
   logic [7:0] r_last_addr, w_last_addr_nxt;
   logic       r_cache_vld, w_cache_vld_nxt;
   logic       r_wr, w_wr_nxt;
   logic       r_a0, w_a0_nxt;
   logic [7:0] r_d, w_d_nxt;
   logic       r_run;
   logic       w_ready, w_accept, w_skip, w_cnt_zero;

   // r_run keeps in_ready low until the first edge after reset release
   assign w_ready    = r_run && (r_state == S_IDLE);
   assign w_accept   = in_valid && w_ready;
   assign w_skip     = C_SKIP_EN && r_cache_vld && (in_addr == r_last_addr);
   assign w_cnt_zero = (r_cnt == 8'd0);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_addr_nxt      = r_addr;
      w_data_nxt      = r_data;
      w_last_addr_nxt = r_last_addr;
      w_cache_vld_nxt = r_cache_vld;
      w_wr_nxt        = r_wr;
      w_a0_nxt        = r_a0;
      w_d_nxt         = r_d;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_addr_nxt = in_addr;
               w_data_nxt = in_data;
               w_cnt_nxt  = C_WR_LOAD;
               w_wr_nxt   = 1'b1;
               if (w_skip) begin
                  w_state_nxt = S_DATA_WR;
                  w_a0_nxt    = 1'b1;
                  w_d_nxt     = in_data;
               end else begin
                  w_state_nxt = S_ADDR_WR;
                  w_a0_nxt    = 1'b0;
                  w_d_nxt     = in_addr;
               end
            end
         end
         S_ADDR_WR: begin
            if (w_cnt_zero) begin
               w_state_nxt     = S_ADDR_WAIT;
               w_cnt_nxt       = C_AW_LOAD;
               w_wr_nxt        = 1'b0;
               w_last_addr_nxt = r_addr;
               w_cache_vld_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_ADDR_WAIT: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_DATA_WR;
               w_cnt_nxt   = C_WR_LOAD;
               w_wr_nxt    = 1'b1;
               w_a0_nxt    = 1'b1;
               w_d_nxt     = r_data;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_DATA_WR: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_DATA_WAIT;
               w_cnt_nxt   = C_DW_LOAD;
               w_wr_nxt    = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_DATA_WAIT: begin
            if (w_cnt_zero) w_state_nxt = S_IDLE;
            else            w_cnt_nxt   = r_cnt - 8'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_addr      <= 8'd0;
         r_data      <= 8'd0;
         r_last_addr <= 8'd0;
         r_cache_vld <= 1'b0;
         r_wr        <= 1'b0;
         r_a0        <= 1'b0;
         r_d         <= 8'd0;
         r_run       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_addr      <= w_addr_nxt;
         r_data      <= w_data_nxt;
         r_last_addr <= w_last_addr_nxt;
         r_cache_vld <= w_cache_vld_nxt;
         r_wr        <= w_wr_nxt;
         r_a0        <= w_a0_nxt;
         r_d         <= w_d_nxt;
         r_run       <= 1'b1;
      end
   end

   assign in_ready = w_ready;
   assign o_busy   = ~w_ready;
   assign o_WR     = r_wr;
   assign o_A0     = r_a0;
   assign o_D      = r_d;

endmodule

// File: tb/tb_opll_write_sequencer.sv
// tb/tb_opll_write_sequencer.sv - directed bench for opll_write_sequencer
// Instance 0 uses defaults; instance 1 enables same-address skipping.
module tb_opll_write_sequencer;

   localparam int WP = 4;
   localparam int AW = 12;
   localparam int DW = 84;
   localparam int N_FULL = 2*WP + AW + DW;
   localparam int N_SKIP = WP + DW;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid [2];
   logic [7:0] in_addr  [2];
   logic [7:0] in_data  [2];
   logic       in_ready [2];
   logic [7:0] o_D      [2];
   logic       o_A0     [2];
   logic       o_WR     [2];
   logic       o_busy   [2];

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   opll_write_sequencer #(.WR_PULSE(4), .ADDR_WAIT(12), .DATA_WAIT(84), .SKIP_SAME_ADDR(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_addr(in_addr[0]), .in_data(in_data[0]), .o_D(o_D[0]), .o_A0(o_A0[0]),
      .o_WR(o_WR[0]), .o_busy(o_busy[0]));

   opll_write_sequencer #(.WR_PULSE(4), .ADDR_WAIT(12), .DATA_WAIT(84), .SKIP_SAME_ADDR(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_addr(in_addr[1]), .in_data(in_data[1]), .o_D(o_D[1]), .o_A0(o_A0[1]),
      .o_WR(o_WR[1]), .o_busy(o_busy[1]));

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
   endtask

   // {ready, busy, wr, a0, d}
   function automatic logic [11:0] outs(input int s);
      return {in_ready[s], o_busy[s], o_WR[s], o_A0[s], o_D[s]};
   endfunction

   task automatic accept(input int s, input logic [7:0] a, input logic [7:0] d);
      in_valid[s] = 1'b1;
      in_addr[s]  = a;
      in_data[s]  = d;
      chk("ready_before_accept", 0, {31'd0, in_ready[s]}, 32'd1);
      @(negedge clk);
   endtask

   // Entered at the sample point right after the accepting edge.
   task automatic trace(input int s, input logic [7:0] a, input logic [7:0] d,
                        input bit skip, input bit tog);
      int n;
      logic [11:0] e;
      n = skip ? N_SKIP : N_FULL;
      for (int i = 0; i < n; i++) begin
         if (skip) begin
            if (i < WP) e = {1'b0, 1'b1, 1'b1, 1'b1, d};
            else        e = {1'b0, 1'b1, 1'b0, 1'b1, d};
         end else begin
            if      (i < WP)        e = {1'b0, 1'b1, 1'b1, 1'b0, a};
            else if (i < WP+AW)     e = {1'b0, 1'b1, 1'b0, 1'b0, a};
            else if (i < 2*WP+AW)   e = {1'b0, 1'b1, 1'b1, 1'b1, d};
            else                    e = {1'b0, 1'b1, 1'b0, 1'b1, d};
         end
         chk(skip ? "trace_skip" : "trace_full", i, {20'd0, outs(s)}, {20'd0, e});
         if (tog) begin
            in_addr[s] = 8'($urandom);
            in_data[s] = 8'($urandom);
         end
         @(negedge clk);
      end
      chk("ready_returned", n, {20'd0, outs(s)}, {20'd0, 1'b1, 1'b0, 1'b0, 1'b1, d});
   endtask

   initial begin
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         in_valid[s] = 1'b0;
         in_addr[s]  = 8'h00;
         in_data[s]  = 8'h00;
      end
      #2;
      for (int s = 0; s < 2; s++)
         chk("reset_outputs", 0, {20'd0, outs(s)}, {20'd0, 12'b0100_0000_0000});
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++)
         chk("reset_held", 0, {20'd0, outs(s)}, {20'd0, 12'b0100_0000_0000});
      rst_n = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++)
         chk("ready_after_reset", 0, {31'd0, in_ready[s]}, 32'd1);

      // Basic write with inputs scrambled after acceptance
      accept(0, 8'h10, 8'h5A);
      in_valid[0] = 1'b0;
      trace(0, 8'h10, 8'h5A, 1'b0, 1'b1);

      // Back-to-back: second request waiting with in_valid held
      accept(0, 8'h33, 8'h44);
      in_addr[0] = 8'h55;
      in_data[0] = 8'h66;
      trace(0, 8'h33, 8'h44, 1'b0, 1'b0);
      @(negedge clk);
      in_valid[0] = 1'b0;
      trace(0, 8'h55, 8'h66, 1'b0, 1'b0);

      // Skip instance: cold cache, new address, then repeated address
      accept(1, 8'h00, 8'hAA);
      in_valid[1] = 1'b0;
      trace(1, 8'h00, 8'hAA, 1'b0, 1'b0);
      accept(1, 8'h20, 8'h01);
      in_valid[1] = 1'b0;
      trace(1, 8'h20, 8'h01, 1'b0, 1'b0);
      accept(1, 8'h20, 8'h02);
      in_valid[1] = 1'b0;
      trace(1, 8'h20, 8'h02, 1'b1, 1'b1);

      // Reset during the data strobe
      accept(0, 8'h77, 8'h88);
      in_valid[0] = 1'b0;
      for (int i = 0; i < 17; i++) @(negedge clk);
      chk("in_data_wr", 17, {20'd0, outs(0)}, {20'd0, 4'b0111, 8'h88});
      rst_n = 1'b0;
      #1;
      chk("async_reset", 0, {20'd0, outs(0)}, {20'd0, 12'b0100_0000_0000});
      @(negedge clk);
      chk("reset_no_resume", 0, {20'd0, outs(0)}, {20'd0, 12'b0100_0000_0000});
      rst_n = 1'b1;
      @(negedge clk);
      accept(0, 8'h77, 8'h99);
      in_valid[0] = 1'b0;
      trace(0, 8'h77, 8'h99, 1'b0, 1'b0);
      accept(1, 8'h20, 8'h03);
      in_valid[1] = 1'b0;
      trace(1, 8'h20, 8'h03, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
